smvm_stream: RTL and testbench

SMVM_STREAM -- requirements
Module: smvm_stream

---
 rtl/smvm_stream.sv | 237 +++++++++++++++++++++++
 tb/tb_smvm_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/smvm_stream.sv
// Streaming sparse matrix x dense vector engine: loads a vector, then folds
// LANES-wide groups of (value, column) nonzeros into per-row dot products.
//
// state | meaning
// IDLE  | waiting for start
// VEC   | loading vector elements vec[0..num_cols-1]
// MAT   | accepting matrix nonzeros, issuing lane groups
// DRAIN | last beat taken; waiting for pipeline and output FIFO to empty
module smvm_stream #(
  parameter int LANES      = 4,
  parameter int VAL_W      = 8,
  parameter int VEC_DEPTH  = 128,
  localparam int IDX_W     = $clog2(VEC_DEPTH),
  parameter int ACC_W      = 2*VAL_W + IDX_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W:0]   num_cols,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] val_in,
  input  logic [IDX_W-1:0] col_in,
  input  logic             eor_in,
  input  logic             last_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             col_err
);

  localparam int LCNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PROD_W = 2*VAL_W;

  typedef enum logic [1:0] {S_IDLE, S_VEC, S_MAT, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   col_err_q;

  logic [IDX_W:0] num_cols_q;
  logic [IDX_W:0] vec_cnt_q;
  logic signed [VAL_W-1:0] vec_mem [VEC_DEPTH];

  logic [LCNT_W-1:0]       grp_cnt_q;
  logic signed [VAL_W-1:0] grp_val_q [LANES];
  logic [IDX_W-1:0]        grp_col_q [LANES];
  logic [LANES-1:0]        grp_oob_q;

  logic signed [VAL_W-1:0] iss_val [LANES];
  logic [IDX_W-1:0]        iss_col [LANES];
  logic [LANES-1:0]        iss_oob;

  logic                    s1_valid_q, s1_eor_q;
  logic signed [VAL_W-1:0] s1_val_q [LANES];
  logic [IDX_W-1:0]        s1_col_q [LANES];
  logic [LANES-1:0]        s1_oob_q;

  logic signed [VAL_W-1:0]  vec_op [LANES];
  logic signed [PROD_W-1:0] prod   [LANES];
  logic                     s2_valid_q, s2_eor_q;
  logic signed [PROD_W-1:0] s2_prod_q [LANES];

  logic signed [ACC_W-1:0] acc_q, prod_sum;

  logic [ACC_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] fifo_cnt_q;
  logic              fifo_wr, fifo_rd;
  logic [ACC_W-1:0]  fifo_wdata;

  logic accept, vec_beat, mat_beat, beat_oob, row_end, issue, pipe_empty, fifo_room;

  // Three free slots cover the two groups in flight plus the beat being taken.
  assign fifo_room  = fifo_cnt_q <= FCNT_W'(FIFO_DEPTH - 3);
  assign in_ready   = (state_q == S_VEC) || ((state_q == S_MAT) && fifo_room);
  assign accept     = in_valid && in_ready;
  assign vec_beat   = accept && (state_q == S_VEC);
  assign mat_beat   = accept && (state_q == S_MAT);
  assign beat_oob   = {1'b0, col_in} >= num_cols_q;
  assign row_end    = eor_in || last_in;
  assign issue      = mat_beat && ((grp_cnt_q == LCNT_W'(LANES - 1)) || row_end);
  assign pipe_empty = !s1_valid_q && !s2_valid_q && (fifo_cnt_q == '0);

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign col_err    = col_err_q;
  assign out_valid  = (fifo_cnt_q != '0);
  assign out_data   = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign fifo_rd    = out_valid && out_ready;
  assign fifo_wr    = s2_valid_q && s2_eor_q;
  assign fifo_wdata = acc_q + prod_sum;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_VEC;
      S_VEC:   if (vec_beat && (vec_cnt_q == num_cols_q - (IDX_W+1)'(1))) state_d = S_MAT;
      S_MAT:   if (mat_beat && last_in) state_d = S_DRAIN;
      S_DRAIN: if (pipe_empty) begin
                 state_d = S_IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = S_IDLE;
    endcase
  end

  // Lanes below grp_cnt come from the group register, the current beat fills
  // lane grp_cnt, and lanes above it are zero.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      iss_val[i] = '0;
      iss_col[i] = '0;
      iss_oob[i] = 1'b1;
      if (i < int'(grp_cnt_q)) begin
        iss_val[i] = grp_val_q[i];
        iss_col[i] = grp_col_q[i];
        iss_oob[i] = grp_oob_q[i];
      end else if (i == int'(grp_cnt_q)) begin
        iss_val[i] = val_in;
        iss_col[i] = col_in;
        iss_oob[i] = beat_oob;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      vec_op[i] = s1_oob_q[i] ? '0 : vec_mem[s1_col_q[i]];
      prod[i]   = PROD_W'(s1_val_q[i]) * PROD_W'(vec_op[i]);
    end
  end

  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < LANES; i++) prod_sum = prod_sum + ACC_W'(s2_prod_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      col_err_q  <= 1'b0;
      num_cols_q <= '0;
      vec_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if ((state_q == S_IDLE) && start) begin
        num_cols_q <= num_cols;
        vec_cnt_q  <= '0;
        col_err_q  <= 1'b0;
      end
      if (vec_beat) vec_cnt_q <= vec_cnt_q + (IDX_W+1)'(1);
      if (mat_beat && beat_oob) col_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (vec_beat) vec_mem[vec_cnt_q[IDX_W-1:0]] <= val_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_cnt_q  <= '0;
      grp_oob_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_eor_q   <= 1'b0;
      s1_oob_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_eor_q   <= 1'b0;
      acc_q      <= '0;
      for (int i = 0; i < LANES; i++) begin
        grp_val_q[i] <= '0;
        grp_col_q[i] <= '0;
        s1_val_q[i]  <= '0;
        s1_col_q[i]  <= '0;
        s2_prod_q[i] <= '0;
      end
    end else begin
      if (mat_beat) begin
        if (issue) begin
          grp_cnt_q <= '0;
        end else begin
          grp_val_q[grp_cnt_q] <= val_in;
          grp_col_q[grp_cnt_q] <= col_in;
          grp_oob_q[grp_cnt_q] <= beat_oob;
          grp_cnt_q            <= grp_cnt_q + LCNT_W'(1);
        end
      end
      s1_valid_q <= issue;
      if (issue) begin
        s1_eor_q <= row_end;
        s1_oob_q <= iss_oob;
        for (int i = 0; i < LANES; i++) begin
          s1_val_q[i] <= iss_val[i];
          s1_col_q[i] <= iss_col[i];
        end
      end
      s2_valid_q <= s1_valid_q;
      s2_eor_q   <= s1_valid_q && s1_eor_q;
      if (s1_valid_q) begin
        for (int i = 0; i < LANES; i++) s2_prod_q[i] <= prod[i];
      end
      if (s2_valid_q) acc_q <= s2_eor_q ? '0 : acc_q + prod_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= fifo_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_wr)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (fifo_rd)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_smvm_stream.sv
// Self-checking bench for smvm_stream: beat table plus hand sequences, with a
// scoreboard queue of expected row results checked as results are consumed.
module tb_smvm_stream;
  localparam int LANES = 4, VAL_W = 8, VEC_DEPTH = 128, IDX_W = 7, ACC_W = 23, FIFO_DEPTH = 8;

  logic             clk, rst_n, start, in_valid, in_ready, eor_in, last_in;
  logic [IDX_W:0]   num_cols;
  logic [VAL_W-1:0] val_in;
  logic [IDX_W-1:0] col_in;
  logic             out_valid, out_ready, busy, done, col_err;
  logic [ACC_W-1:0] out_data;

  smvm_stream #(.LANES(LANES), .VAL_W(VAL_W), .VEC_DEPTH(VEC_DEPTH), .ACC_W(ACC_W),
                .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_cols(num_cols),
    .in_valid(in_valid), .in_ready(in_ready), .val_in(val_in), .col_in(col_in),
    .eor_in(eor_in), .last_in(last_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .col_err(col_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int sb[$];
  int vec_arr[VEC_DEPTH];

  typedef struct packed {
    logic [7:0] val;
    logic [6:0] col;
    logic       eor;
    logic       last;
    int         expv;
  } beat_t;
  beat_t tbl[17];

  task automatic check(input string name, input int act, input int exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %0d expected no output", int'($signed(out_data)));
      end else begin
        check("row_result", int'($signed(out_data)), sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] v, input logic [6:0] c, input logic e, input logic l);
    int n = 0;
    in_valid = 1'b1; val_in = v; col_in = c; eor_in = e; last_in = l;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_accept_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; eor_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    num_cols = 8'(n);
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("col_err_cleared", int'(col_err), 0);
    for (int i = 0; i < n; i++) send_beat(8'(vec_arr[i]), 7'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    check(name, int'(done), 1);
    tick();
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{8'd2,   7'd0, 1'b1, 1'b0, 6},
      '{8'd5,   7'd1, 1'b0, 1'b0, 0},
      '{8'hFD,  7'd2, 1'b0, 1'b0, 0},
      '{8'd1,   7'd4, 1'b1, 1'b0, -22},
      '{8'd10,  7'd7, 1'b0, 1'b0, 0},
      '{8'hFE,  7'd5, 1'b0, 1'b0, 0},
      '{8'd7,   7'd3, 1'b0, 1'b0, 0},
      '{8'd1,   7'd6, 1'b0, 1'b0, 0},
      '{8'hFF,  7'd0, 1'b1, 1'b0, -72},
      '{8'd0,   7'd0, 1'b1, 1'b0, 0},
      '{8'd127, 7'd2, 1'b0, 1'b0, 0},
      '{8'd127, 7'd5, 1'b0, 1'b0, 0},
      '{8'h80,  7'd1, 1'b0, 1'b0, 0},
      '{8'h80,  7'd7, 1'b1, 1'b0, 2547},
      '{8'h80,  7'd3, 1'b0, 1'b0, 0},
      '{8'h80,  7'd4, 1'b1, 1'b0, 512},
      '{8'd3,   7'd6, 1'b0, 1'b0, 0}
    };
    rst_n = 1'b0; start = 1'b0; num_cols = '0; in_valid = 1'b0; val_in = '0;
    col_in = '0; eor_in = 1'b0; last_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_col_err", int'(col_err), 0);
    rst_n = 1'b1;
    tick();

    // Table job: 7 rows over an 8-entry vector; last row ends on last_in only.
    vec_arr[0] = 3; vec_arr[1] = -1; vec_arr[2] = 4; vec_arr[3] = 1;
    vec_arr[4] = -5; vec_arr[5] = 9; vec_arr[6] = 2; vec_arr[7] = -6;
    start_job(8);
    for (int k = 0; k < 17; k++) begin
      if (tbl[k].eor || tbl[k].last) sb.push_back(tbl[k].expv);
      send_beat(tbl[k].val, tbl[k].col, tbl[k].eor, tbl[k].last);
    end
    sb.push_back(17);
    send_beat(8'd1, 7'd0, 1'b0, 1'b0);
    send_beat(8'd1, 7'd1, 1'b0, 1'b0);
    send_beat(8'd1, 7'd5, 1'b0, 1'b1);
    wait_done("done_table");
    check("col_err_table", int'(col_err), 0);

    // Out-of-range column uses operand 0 and sets sticky col_err.
    for (int i = 0; i < 4; i++) vec_arr[i] = i + 1;
    start_job(4);
    sb.push_back(4);
    send_beat(8'd2, 7'd1, 1'b0, 1'b0);
    send_beat(8'd5, 7'd7, 1'b1, 1'b1);
    wait_done("done_colerr");
    check("col_err_sticky", int'(col_err), 1);

    // Basic row with latency check: eor accepted at edge E, result after E+2.
    start_job(4);
    send_beat(8'd5, 7'd0, 1'b0, 1'b0);
    sb.push_back(-3);
    send_beat(8'hFE, 7'd3, 1'b1, 1'b1);
    check("lat_e0_valid", int'(out_valid), 0);
    tick();
    check("lat_e1_valid", int'(out_valid), 0);
    tick();
    check("lat_e2_valid", int'(out_valid), 1);
    check("lat_e2_data", int'($signed(out_data)), -3);
    wait_done("done_basic");

    // Nine-nonzero row spans three groups and yields a single result.
    for (int i = 0; i < 9; i++) vec_arr[i] = 1;
    start_job(9);
    sb.push_back(9);
    for (int i = 0; i < 9; i++) send_beat(8'd1, 7'(i), 1'(i == 8), 1'(i == 8));
    wait_done("done_multigroup");

    // Backpressure: ten one-nonzero rows with the consumer stalled.
    for (int i = 0; i < 4; i++) vec_arr[i] = i + 1;
    start_job(4);
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("in_ready_3free", int'(in_ready), 1);
      sb.push_back((k + 1) * vec_arr[k % 4]);
      send_beat(8'(k + 1), 7'(k % 4), 1'b1, 1'b0);
    end
    check("in_ready_2free", int'(in_ready), 0);
    repeat (4) tick();
    check("in_ready_held", int'(in_ready), 0);
    check("out_valid_held", int'(out_valid), 1);
    out_ready = 1'b1;
    for (int k = 8; k < 10; k++) begin
      sb.push_back((k + 1) * vec_arr[k % 4]);
      send_beat(8'(k + 1), 7'(k % 4), 1'b1, 1'(k == 9));
    end
    wait_done("done_backpressure");

    // Full-length extreme-value row: 128 * (-128 * -128) without wrap.
    for (int i = 0; i < VEC_DEPTH; i++) vec_arr[i] = -128;
    start_job(128);
    sb.push_back(2097152);
    for (int i = 0; i < 128; i++) send_beat(8'h80, 7'(i), 1'(i == 127), 1'(i == 127));
    wait_done("done_extreme");

    // Reset mid-MAT with results pending, then a fresh job.
    for (int i = 0; i < 4; i++) vec_arr[i] = i + 1;
    start_job(4);
    out_ready = 1'b0;
    send_beat(8'd5, 7'd0, 1'b1, 1'b0);
    send_beat(8'd2, 7'd3, 1'b1, 1'b0);
    repeat (3) tick();
    check("pre_reset_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) vec_arr[i] = 10 * (i + 1);
    start_job(4);
    sb.push_back(70);
    send_beat(8'd1, 7'd2, 1'b0, 1'b0);
    send_beat(8'd1, 7'd3, 1'b1, 1'b1);
    wait_done("done_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
